// File: rtl/src_loader.sv
// src_loader: fill stage for the ping-pong source buffer.
// Takes 64-bit stream beats and turns each one into a single buffer write. It
// also owns the bank-select bit p, which flips only after a whole block has
// been written and the exec side has released its bank.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, len            one-cycle block request and its length in beats
//   s_tdata/tvalid/tready/tlast  64-bit input stream
//   exec_busy             exec side is still reading the current read bank
//   src_v/src_a/src_d     buffer write strobe, beat address, data
//   p                     bank select (1: write bank0, exec reads bank1)
//   load_done             one-cycle pulse, coincident with the p toggle
//   busy                  high outside IDLE
//   err_len               sticky length/tlast error, cleared only by reset
module src_loader #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [63:0]       s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic              exec_busy,
  output logic              src_v,
  output logic [ADDR_W-1:0] src_a,
  output logic [63:0]       src_d,
  output logic              p,
  output logic              load_done,
  output logic              busy,
  output logic              err_len
);

  typedef enum logic [1:0] {StIdle, StLoad, StSwap} state_e;

  // Largest legal block: one beat per buffer address.
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(1) << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   last_q, last_d;   // index of the final beat (len-1)
  logic [ADDR_W-1:0]   cnt_q, cnt_d;     // index of the next beat to accept
  logic                src_v_q, src_v_d;
  logic [ADDR_W-1:0]   src_a_q, src_a_d;
  logic [63:0]         src_d_q, src_d_d;
  logic                p_q, p_d;
  logic                load_done_q, load_done_d;
  logic                err_len_q, err_len_d;
  logic                is_last;

  assign is_last = (cnt_q == last_q);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    src_v_d     = 1'b0;
    src_a_d     = src_a_q;
    src_d_d     = src_d_q;
    p_d         = p_q;
    load_done_d = 1'b0;
    err_len_d   = err_len_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len > MaxLen) begin
            err_len_d = 1'b1;
          end else if (len != '0) begin
            // len fits in ADDR_W+1 bits here, so len-1 fits in ADDR_W bits.
            last_d  = ADDR_W'(len - LEN_W'(1));
            cnt_d   = '0;
            src_a_d = '0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (s_tvalid) begin
          src_v_d = 1'b1;
          src_a_d = cnt_q;
          src_d_d = s_tdata;
          cnt_d   = cnt_q + ADDR_W'(1);
          // tlast must coincide exactly with the counted final beat; the
          // block always ends on the count regardless.
          if (s_tlast != is_last) err_len_d = 1'b1;
          if (is_last) state_d = StSwap;
        end
      end
      StSwap: begin
        if (!exec_busy) begin
          p_d         = ~p_q;
          load_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= '0;
      cnt_q       <= '0;
      src_v_q     <= 1'b0;
      src_a_q     <= '0;
      src_d_q     <= '0;
      p_q         <= 1'b0;
      load_done_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      src_v_q     <= src_v_d;
      src_a_q     <= src_a_d;
      src_d_q     <= src_d_d;
      p_q         <= p_d;
      load_done_q <= load_done_d;
      err_len_q   <= err_len_d;
    end
  end

  assign s_tready  = (state_q == StLoad);
  assign busy      = (state_q != StIdle);
  assign src_v     = src_v_q;
  assign src_a     = src_a_q;
  assign src_d     = src_d_q;
  assign p         = p_q;
  assign load_done = load_done_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_src_loader.sv
// Directed bench for src_loader with hand-computed expectations.
module tb_src_loader;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned LEN_W  = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [63:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic              exec_busy;
  logic              src_v;
  logic [ADDR_W-1:0] src_a;
  logic [63:0]       src_d;
  logic              p;
  logic              load_done;
  logic              busy;
  logic              err_len;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  src_loader #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .exec_busy(exec_busy),
    .src_v    (src_v),
    .src_a    (src_a),
    .src_d    (src_d),
    .p        (p),
    .load_done(load_done),
    .busy     (busy),
    .err_len  (err_len)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are then stable for sampling and inputs set
  // now are seen at the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    start = 1'b0;
    len   = '0;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = 64'hDEAD_DEAD_DEAD_DEAD;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [63:0] dv [4];
  logic [4:0]  pat;
  int          idx;
  logic [63:0] last_d;
  logic [18:0] last_a;

  initial begin
    dv[0] = 64'h1111_1111_0000_0000;
    dv[1] = 64'h2222_2222_0000_0001;
    dv[2] = 64'h3333_3333_0000_0002;
    dv[3] = 64'h4444_4444_0000_0003;
    rst_n = 1'b0; start = 1'b0; len = '0; s_tdata = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; exec_busy = 1'b0;
    step();
    step();
    check("rst_tready", s_tready, 0);
    check("rst_src_v", src_v, 0);
    check("rst_src_a", src_a, 0);
    check("rst_src_d", src_d, 0);
    check("rst_p", p, 0);
    check("rst_done", load_done, 0);
    check("rst_err", err_len, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

    // len==0 is silently ignored.
    do_start('0);
    check("len0_busy", busy, 0);
    check("len0_err", err_len, 0);

    // Test 1: len=4, back-to-back beats.
    do_start(20'd4);
    check("t1_busy", busy, 1);
    check("t1_tready", s_tready, 1);
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = dv[i]; s_tlast = (i == 3);
      step();
      check("t1_src_v", src_v, 1);
      check("t1_src_a", src_a, 64'(i));
      check("t1_src_d", src_d, dv[i]);
      check("t1_p_old", p, 0);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t1_swap_tready", s_tready, 0);
    step();
    check("t1_p", p, 1);
    check("t1_done", load_done, 1);
    check("t1_src_v_off", src_v, 0);
    check("t1_idle", busy, 0);
    step();
    check("t1_done_once", load_done, 0);
    check("t1_err", err_len, 0);

    // Test 2: len=3 with gaps; hold src_a/src_d in gaps.
    pat = 5'b10101;
    do_start(20'd3);
    idx = 0; last_a = 0; last_d = 0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = pat[i];
      s_tdata  = pat[i] ? dv[idx] : 64'hBAD0_BAD0_BAD0_BAD0;
      s_tlast  = (i == 4);
      step();
      check("t2_src_v", src_v, 64'(pat[i]));
      if (pat[i]) begin
        last_a = 19'(idx);
        last_d = dv[idx];
        idx++;
      end
      check("t2_src_a", src_a, 64'(last_a));
      check("t2_src_d", src_d, last_d);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    step();
    check("t2_p", p, 0);
    check("t2_done", load_done, 1);
    check("t2_err", err_len, 0);

    // Test 3: exec_busy stalls the swap.
    exec_busy = 1'b1;
    do_start(20'd2);
    beat(dv[0], 1'b0);
    beat(dv[1], 1'b1);
    check("t3_last_a", src_a, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_tready", s_tready, 0);
      check("t3_hold_p", p, 0);
      check("t3_hold_done", load_done, 0);
      check("t3_hold_busy", busy, 1);
    end
    exec_busy = 1'b0;
    step();
    check("t3_p", p, 1);
    check("t3_done", load_done, 1);

    // Test 4: two len=1 blocks, second start on the load_done cycle.
    do_reset();
    check("t4_p0", p, 0);
    do_start(20'd1);
    beat(dv[2], 1'b1);
    check("t4_w0_a", src_a, 0);
    check("t4_w0_p", p, 0);
    step();
    check("t4_p1", p, 1);
    check("t4_done1", load_done, 1);
    do_start(20'd1);
    check("t4_restart", busy, 1);
    beat(dv[3], 1'b1);
    check("t4_w1_v", src_v, 1);
    check("t4_w1_a", src_a, 0);
    check("t4_w1_d", src_d, dv[3]);
    check("t4_w1_p", p, 1);
    step();
    check("t4_p2", p, 0);
    check("t4_done2", load_done, 1);

    // Test 5: early tlast, then oversize start.
    do_start(20'd3);
    beat(dv[0], 1'b0);
    check("t5_err_b0", err_len, 0);
    beat(dv[1], 1'b1);
    check("t5_err_b1", err_len, 1);
    check("t5_b1_v", src_v, 1);
    beat(dv[2], 1'b1);
    check("t5_b2_v", src_v, 1);
    check("t5_b2_a", src_a, 2);
    step();
    check("t5_done", load_done, 1);
    do_start(20'h80001);
    check("t5_big_busy", busy, 0);
    check("t5_big_err", err_len, 1);

    // Test 6: reset mid-LOAD, then a clean load.
    do_reset();
    check("t6_err_clr", err_len, 0);
    do_start(20'd1);
    beat(dv[0], 1'b1);
    step();
    check("t6_pre_p", p, 1);
    do_start(20'd5);
    beat(dv[1], 1'b0);
    beat(dv[2], 1'b0);
    do_reset();
    check("t6_busy", busy, 0);
    check("t6_p", p, 0);
    check("t6_tready", s_tready, 0);
    check("t6_done", load_done, 0);
    do_start(20'd1);
    beat(dv[3], 1'b1);
    check("t6_w_v", src_v, 1);
    check("t6_w_a", src_a, 0);
    check("t6_w_d", src_d, dv[3]);
    step();
    check("t6_p1", p, 1);
    check("t6_done1", load_done, 1);
    check("t6_err", err_len, 0);

    // Largest legal length is accepted.
    do_start(20'h80000);
    check("max_busy", busy, 1);
    check("max_err", err_len, 0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
